// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   SEG_A..SEG_DP : bit positions within a segment byte (1 = lit)
//   SEG_BLANK     : all-segments-dark pattern
//   scan_state_t  : scan FSM states (GUARD = all-off gap, DRIVE = digit lit)
//   max_int       : elaboration-time helper for sizing counters
package seg7_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot counter, GUARD/DRIVE FSM and digit index.
// Each digit slot is GUARD_CYCLES dark cycles followed by SCAN_DIV drive
// cycles; the digit index advances (wrapping) at the end of every DRIVE.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   idx           : digit index in effect after the coming clock edge
//   in_drive      : FSM will be in DRIVE after the coming clock edge
//   drive_count   : slot counter value after the coming clock edge
//   drive_start   : coming edge moves GUARD -> DRIVE
//   frame_end     : coming edge ends DRIVE of the last digit
// idx/in_drive/drive_count are lookahead values so that output registers
// in the parent load on the same edge as this FSM and stay in step with it.
module seg7_scan_timer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 1024,
   parameter int GUARD_CYCLES = 16,
   localparam int IDX_W       = $clog2(NUM_DIGITS),
   localparam int CNT_W       = $clog2(max_int(SCAN_DIV, GUARD_CYCLES))
)(
   input  logic             clock,
   input  logic             reset,
   output logic [IDX_W-1:0] idx,
   output logic             in_drive,
   output logic [CNT_W-1:0] drive_count,
   output logic             drive_start,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CNT_W'(1);
      idx_nxt     = idx_q;
      drive_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         GUARD: begin
            if (cnt == GUARD_LAST) begin
               state_nxt   = DRIVE;
               cnt_nxt     = '0;
               drive_start = 1'b1;
            end
         end
         DRIVE: begin
            if (cnt == DRIVE_LAST) begin
               state_nxt = GUARD;
               cnt_nxt   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_nxt   = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_nxt = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = GUARD;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= GUARD;
         cnt   <= '0;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx_q <= idx_nxt;
      end
   end

   assign idx         = idx_nxt;
   assign in_drive    = (state_nxt == DRIVE);
   assign drive_count = cnt_nxt;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed 7-segment driver.
// A frame loaded through the valid/ready handshake lands in a pending
// buffer and is promoted to the active buffer only at a frame boundary,
// so a scan never mixes digits from two frames.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   load_valid    : producer offers load_data
//   load_ready    : pending buffer empty (registered)
//   load_data     : digit i pattern at [8i+7:8i], digit 0 rightmost
//   seg_out       : segment bus, inverted when SEG_ACTIVE_LOW != 0
//   dig_sel       : one-hot digit enable, inverted when DIG_ACTIVE_LOW != 0
//   frame_done    : one-cycle pulse after each frame boundary
//   dim_level     : (SEG7_DIM_EN only) drive duty in sixteenths, minus one
// Build option: define SEG7_DIM_EN to add dim_level brightness control.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV       = 1024,
   parameter int GUARD_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [8*NUM_DIGITS-1:0] load_data,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
`ifdef SEG7_DIM_EN
   ,
   input  logic [3:0]              dim_level
`endif
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = $clog2(max_int(SCAN_DIV, GUARD_CYCLES));

   // Idle levels double as XOR masks to apply pin polarity.
   localparam logic [7:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [IDX_W-1:0]        idx;
   logic                    in_drive;
   logic [CNT_W-1:0]        drive_count;
   logic                    drive_start;
   logic                    frame_end;

   logic [8*NUM_DIGITS-1:0] active;
   logic [8*NUM_DIGITS-1:0] pending;
   logic                    pending_full;
   logic                    xfer;
   logic                    swap;
   logic [7:0]              cur_byte;
   logic [NUM_DIGITS-1:0]   onehot;
   logic                    lit;

   seg7_scan_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_timer (
      .clock       (clock),
      .reset       (reset),
      .idx         (idx),
      .in_drive    (in_drive),
      .drive_count (drive_count),
      .drive_start (drive_start),
      .frame_end   (frame_end)
   );

   // load_ready mirrors !pending_full, so a transfer (pending empty) and a
   // promotion (pending full) can never coincide on one edge.
   assign xfer = load_valid & load_ready;
   assign swap = frame_end & pending_full;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         load_ready   <= 1'b1;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (swap) begin
            active <= pending;
         end
         if (xfer) begin
            pending      <= load_data;
            pending_full <= 1'b1;
            load_ready   <= 1'b0;
         end else if (swap) begin
            pending_full <= 1'b0;
            load_ready   <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_byte = SEG_BLANK;
      onehot   = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_byte  = active[8*i +: 8];
            onehot[i] = 1'b1;
         end
      end
   end

`ifdef SEG7_DIM_EN
   logic [3:0]  dim_q;
   logic [3:0]  dim_eff;
   logic [31:0] lit_limit;

   // The level used for the first cycle of a slot is the live input, so the
   // whole slot runs on the value seen at DRIVE entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dim_q <= '0;
      end else if (drive_start) begin
         dim_q <= dim_level;
      end
   end

   assign dim_eff   = drive_start ? dim_level : dim_q;
   assign lit_limit = ((32'(dim_eff) + 32'd1) * 32'(SCAN_DIV)) >> 4;
   assign lit       = in_drive && (32'(drive_count) < lit_limit);
`else
   logic unused_drive_count;
   logic unused_drive_start;

   assign unused_drive_count = ^drive_count;
   assign unused_drive_start = drive_start;
   assign lit                = in_drive;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_out <= SEG_IDLE;
         dig_sel <= DIG_IDLE;
      end else if (lit) begin
         seg_out <= cur_byte ^ SEG_IDLE;
         dig_sel <= onehot ^ DIG_IDLE;
      end else begin
         seg_out <= SEG_IDLE;
         dig_sel <= DIG_IDLE;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int SD    = 4;
   localparam int GC    = 1;
   localparam int SLOT  = SD + GC;
   localparam int FRAME = N * SLOT;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           load_valid = 1'b0;
   logic [8*N-1:0] load_data = '0;

   logic [7:0]     seg_out, seg_out_n;
   logic [N-1:0]   dig_sel, dig_sel_n;
   logic           load_ready, load_ready_n;
   logic           frame_done, frame_done_n;
`ifdef SEG7_DIM_EN
   logic [3:0]     dim_level = 4'hF;
`endif

   always #5 clock = ~clock;

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(GC),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) dut (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
`ifdef SEG7_DIM_EN
      , .dim_level(dim_level)
`endif
   );

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(GC),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dut_n (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_n),
      .load_data(load_data), .seg_out(seg_out_n), .dig_sel(dig_sel_n), .frame_done(frame_done_n)
`ifdef SEG7_DIM_EN
      , .dim_level(dim_level)
`endif
   );

   typedef struct packed {
      logic [7:0]   seg;
      logic [N-1:0] dig;
      logic         rdy;
      logic         fd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: frame-level view of the display.
   int             t;
   logic [8*N-1:0] m_act, m_pend;
   logic           m_full;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   function automatic exp_t expect_now();
      exp_t         e;
      int           slot, pos;
      logic [N-1:0] one;
      one   = 1;
      slot  = (t % FRAME) / SLOT;
      pos   = (t % FRAME) % SLOT;
      e.seg = (pos >= GC) ? m_act[8*slot +: 8] : 8'h00;
      e.dig = (pos >= GC) ? (one << slot) : '0;
      e.rdy = !m_full;
      e.fd  = (t > 0) && ((t % FRAME) == 0);
      return e;
   endfunction

   task automatic model_edge(output bit acc);
      bit swp;
      acc = load_valid && !m_full;
      swp = ((t % FRAME) == FRAME - 1) && m_full;
      if (swp) begin
         m_act  = m_pend;
         m_full = 1'b0;
      end
      if (acc) begin
         m_pend = load_data;
         m_full = 1'b1;
      end
      t++;
   endtask

   task automatic model_reset();
      t      = 0;
      m_act  = '0;
      m_pend = '0;
      m_full = 1'b0;
   endtask

   // directed: offers at fixed cycles; otherwise random offers.
   task automatic run(input int ncycles, input bit directed);
      bit acc;
      repeat (ncycles) begin
         sb.push_back(expect_now());
         if (!load_valid) begin
            if (directed) begin
               if (t == 2) begin
                  load_data  = 32'hB666F260;
                  load_valid = 1'b1;
               end else if (t == 39) begin
                  load_data  = 32'h3F065B4F;
                  load_valid = 1'b1;
               end else if (t == 45) begin
                  load_data  = 32'h6D7D0781;
                  load_valid = 1'b1;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               for (int b = 0; b < N; b++) load_data[8*b +: 8] = 8'($urandom);
               load_valid = 1'b1;
            end
         end
         @(posedge clock);
         model_edge(acc);
         #1;
         if (acc) load_valid = 1'b0;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_seg"},   64'(seg_out),      64'h00);
      check({tag, "_dig"},   64'(dig_sel),      64'h0);
      check({tag, "_rdy"},   64'(load_ready),   64'h1);
      check({tag, "_fd"},    64'(frame_done),   64'h0);
      check({tag, "_seg_n"}, 64'(seg_out_n),    64'hFF);
      check({tag, "_dig_n"}, 64'(dig_sel_n),    64'hF);
      check({tag, "_rdy_n"}, 64'(load_ready_n), 64'h1);
   endtask

   // Monitor: every cycle the DUTs present outputs; compare against queue.
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("scan", 64'({seg_out, dig_sel, load_ready, frame_done}), 64'(e));
         check("scan_lowpol", 64'({seg_out_n, dig_sel_n, load_ready_n, frame_done_n}),
               64'({~e.seg, ~e.dig, e.rdy, e.fd}));
      end
   end

   initial begin
      int k;
      model_reset();
      #1 reset = 1'b1;
      #1 check_idle("reset_async");
      repeat (3) @(posedge clock);
      #1 check_idle("reset_held");
      @(posedge clock);
      #1 reset = 1'b0;

      run(100, 1'b1);
      run(300, 1'b0);

      // Bring the scan to the middle of digit 2's drive, then reset.
      k = (12 - (t % FRAME) + FRAME) % FRAME;
      run(k, 1'b0);
      sb.push_back(expect_now());
      @(negedge clock);
      #1;
      check("pre_reset_dig", 64'(dig_sel), 64'h4);
      load_valid = 1'b0;
      reset      = 1'b1;
      #1 check_idle("reset_mid_drive");
      @(posedge clock);
      #1 check_idle("reset_mid_edge");
      reset = 1'b0;
      model_reset();

      run(120, 1'b0);
      @(negedge clock);
      #1 check("sb_drain", 64'(sb.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
